// File: rtl/wb_arbxbar_pkg.sv
// ----------------------------------------------------------------------------
// wb_arbxbar_pkg : shared types, SoC default memory map and round-robin helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package wb_arbxbar_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int MAX_M = 8;

  // bram 0x0, i2c 0x2, spi 0x3, gpio 0x4, timer 0x5, uart 0x6 (slave 0 in the LSBs)
  localparam int                 SOC_S_ADDR_W = 3;
  localparam logic [6*3-1:0]     SOC_S_ADDR   = {3'b110, 3'b101, 3'b100,
                                                 3'b011, 3'b010, 3'b000};

  // First requester searching upward from (last+1) mod nm; returns last if none.
  function automatic logic [2:0] rr_next(input logic [MAX_M-1:0] req,
                                         input logic [2:0]       last,
                                         input int               nm);
    logic [2:0] idx;
    int         cand;
    idx = last;
    for (int i = MAX_M; i >= 1; i--) begin
      if (i <= nm) begin
        cand = (int'(last) + i) % nm;
        if (req[cand[2:0]]) idx = cand[2:0];
      end
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbxbar_rr.sv
// ----------------------------------------------------------------------------
// wb_arbxbar_rr : NM-wide round-robin arbiter producing a one-hot grant
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_arbxbar_rr
  import wb_arbxbar_pkg::*;
#(
  parameter int NM = 2,
  parameter int LW = 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [LW-1:0] last_gnt_i,
  input  logic          enable_i,
  output logic [NM-1:0] gnt_o
);

  logic [MAX_M-1:0] req_w;
  logic [2:0]       last_w;
  logic [2:0]       idx_w;

  always_comb begin
    req_w             = '0;
    req_w[NM-1:0]     = req_i;
    last_w            = '0;
    last_w[LW-1:0]    = last_gnt_i;
    idx_w             = rr_next(req_w, last_w, NM);
    gnt_o             = '0;
    for (int k = 0; k < NM; k++) begin
      gnt_o[k] = enable_i && (|req_i) && (idx_w == 3'(k));
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbxbar.sv
// ----------------------------------------------------------------------------
// wb_arbxbar : shared-bus Wishbone interconnect, NM masters to NS slaves with
//              round-robin arbitration, address decode, unmapped err, watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_arbxbar
  import wb_arbxbar_pkg::*;
#(
  parameter int                         NM       = 2,
  parameter int                         NS       = 6,
  parameter int                         S_ADDR_W = SOC_S_ADDR_W,
  parameter logic [NS*S_ADDR_W-1:0]     S_ADDR   = SOC_S_ADDR,
  parameter int                         TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,        // asynchronous, active-low
  input  logic [NM*32-1:0]     m_adr_i,
  input  logic [NM*32-1:0]     m_dat_i,
  input  logic [NM*4-1:0]      m_sel_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  output logic [31:0]          m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [31:0]          s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic [NS-1:0]        s_cyc_o,
  output logic [NS-1:0]        s_stb_o,
  input  logic [NS*32-1:0]     s_dat_i,
  input  logic [NS-1:0]        s_ack_i,
  output logic [NM-1:0]        gnt_o
);

  localparam int             LW      = (NM > 1) ? $clog2(NM) : 1;
  localparam int             SW      = (NS > 1) ? $clog2(NS) : 1;
  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  WD_LAST = CW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [NM-1:0]   gnt_q, gnt_d, rr_gnt;
  logic [LW-1:0]   last_q, last_d, gidx;
  logic [CW-1:0]   wd_q, wd_d;
  logic            err_q, err_d;

  logic [31:0]     adr_g, dat_g;
  logic [3:0]      sel_g;
  logic            we_g, cyc_g, stb_g;
  logic            busy, hit, sel_ok, ack_w;
  logic [SW-1:0]   sidx;
  logic [NS-1:0]   ssel;

  assign busy = (state_q == BUSY);

  wb_arbxbar_rr #(
    .NM (NM),
    .LW (LW)
  ) u_rr (
    .req_i      (m_cyc_i),
    .last_gnt_i (last_q),
    .enable_i   (state_q == IDLE),
    .gnt_o      (rr_gnt)
  );

  // Granted master mux; all zero while no grant is held.
  always_comb begin
    adr_g = '0;
    dat_g = '0;
    sel_g = '0;
    we_g  = 1'b0;
    gidx  = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q[i]) begin
        adr_g = adr_g | m_adr_i[i*32 +: 32];
        dat_g = dat_g | m_dat_i[i*32 +: 32];
        sel_g = sel_g | m_sel_i[i*4 +: 4];
        we_g  = we_g  | m_we_i[i];
        gidx  = LW'(i);
      end
    end
    cyc_g = |(m_cyc_i & gnt_q);
    stb_g = |(m_stb_i & gnt_q);
  end

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    hit  = 1'b0;
    sidx = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (adr_g[31 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
        hit  = 1'b1;
        sidx = SW'(k);
      end
    end
    sel_ok = busy && hit;
    ssel   = '0;
    for (int k = 0; k < NS; k++) begin
      ssel[k] = sel_ok && (sidx == SW'(k));
    end
    ack_w   = sel_ok && stb_g && s_ack_i[sidx];
    m_dat_o = sel_ok ? s_dat_i[32*int'(sidx) +: 32] : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = BUSY;
          gnt_d   = rr_gnt;
        end
      end
      BUSY: begin
        if (!cyc_g) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = gidx;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // An ack in the firing cycle suppresses the err; err itself clears the count.
  always_comb begin
    wd_d  = '0;
    err_d = 1'b0;
    if (busy && stb_g && !ack_w && !err_q) begin
      if (cyc_g && (!hit || (wd_q == WD_LAST))) begin
        err_d = 1'b1;
      end else if (wd_q != {CW{1'b1}}) begin
        wd_d = wd_q + 1'b1;
      end else begin
        wd_d = wd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(NM - 1);
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign m_ack_o = gnt_q & {NM{ack_w}};
  assign m_err_o = gnt_q & {NM{err_q}};
  assign s_cyc_o = ssel & {NS{cyc_g}};
  assign s_stb_o = ssel & {NS{stb_g}};
  assign s_adr_o = adr_g;
  assign s_dat_o = dat_g;
  assign s_sel_o = sel_g;
  assign s_we_o  = we_g;
  assign gnt_o   = gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbxbar.sv
// ----------------------------------------------------------------------------
// tb_wb_arbxbar : directed self-checking bench for wb_arbxbar (NM=2, NS=6, TIMEOUT=8)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wb_arbxbar;

  localparam int NM = 2;
  localparam int NS = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*32-1:0]  m_adr, m_dat;
  logic [NM*4-1:0]   m_sel;
  logic [NM-1:0]     m_we, m_cyc, m_stb;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, gnt_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o, s_ack_i;
  logic [NS*32-1:0]  s_dat_i;

  int ack_dly [NS];
  int stb_cnt [NS];
  int n_checks = 0;
  int n_errors = 0;
  int n;

  wb_arbxbar #(
    .NM      (NM),
    .NS      (NS),
    .TIMEOUT (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_we_i  (m_we),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .gnt_o   (gnt_o)
  );

  always #5 clk = ~clk;

  for (genvar k = 0; k < NS; k++) begin : g_sdat
    assign s_dat_i[k*32 +: 32] = 32'hD000_0000 | 32'(k);
  end

  // Slave k acks on the ack_dly[k]-th cycle of its strobe; 0 means never.
  always_comb begin
    s_ack_i = '0;
    for (int k = 0; k < NS; k++) begin
      s_ack_i[k] = s_stb_o[k] && (ack_dly[k] != 0) && (stb_cnt[k] == ack_dly[k] - 1);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      stb_cnt[k] <= (s_stb_o[k] && !s_ack_i[k]) ? stb_cnt[k] + 1 : 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic req(input int m, input logic [31:0] adr, input logic we);
    m_adr[m*32 +: 32] = adr;
    m_dat[m*32 +: 32] = 32'h1234_5678;
    m_sel[m*4 +: 4]   = 4'hF;
    m_we[m]           = we;
    m_cyc[m]          = 1'b1;
    m_stb[m]          = 1'b1;
  endtask

  task automatic rel(input int m);
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [NM-1:0] exp_g;
    for (int k = 0; k < NS; k++) ack_dly[k] = 0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    m_we  = '0; m_cyc = '0; m_stb = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check_eq("rst_gnt",  32'(gnt_o),   32'h0);
    check_eq("rst_scyc", 32'(s_cyc_o), 32'h0);
    check_eq("rst_sstb", 32'(s_stb_o), 32'h0);
    check_eq("rst_ack",  32'(m_ack_o), 32'h0);
    check_eq("rst_err",  32'(m_err_o), 32'h0);
    check_eq("rst_mdat", m_dat_o,      32'h0);
    check_eq("rst_sadr", s_adr_o,      32'h0);
    nxt(); nxt();
    rst = 1'b1;

    // BRAM read, slave acks on its second strobe cycle
    ack_dly[0] = 2;
    nxt(); req(0, 32'h0000_0010, 1'b0); settle();
    check_eq("rd_nognt", 32'(gnt_o),   32'h0);
    check_eq("rd_noscyc",32'(s_cyc_o), 32'h0);
    nxt(); settle();
    check_eq("rd_gnt",   32'(gnt_o),   32'h1);
    check_eq("rd_scyc",  32'(s_cyc_o), 32'h01);
    check_eq("rd_sadr",  s_adr_o,      32'h0000_0010);
    check_eq("rd_noack", 32'(m_ack_o), 32'h0);
    nxt(); settle();
    check_eq("rd_ack",   32'(m_ack_o), 32'h1);
    check_eq("rd_mdat",  m_dat_o,      32'hD000_0000);
    nxt(); rel(0); settle();
    check_eq("rd_ack1",  32'(m_ack_o), 32'h0);
    nxt(); settle();
    check_eq("rd_idle",  32'(gnt_o),   32'h0);

    // Both masters contend; last release was master 0 so master 1 goes first
    nxt(); m_cyc = 2'b11;
    exp_g = 2'b10;
    for (int t = 0; t < 4; t++) begin
      nxt(); settle();
      check_eq("rr_gnt", 32'(gnt_o), 32'(exp_g));
      for (int c = 1; c <= 3; c++) begin
        nxt();
        if (c == 3) m_cyc = m_cyc & ~exp_g;
        settle();
        check_eq("rr_hold", 32'(gnt_o), 32'(exp_g));
      end
      nxt();
      if (t < 3) m_cyc = m_cyc | exp_g;
      else       m_cyc = '0;
      settle();
      check_eq("rr_idle", 32'(gnt_o), 32'h0);
      exp_g = ~exp_g;
    end

    // Prefix 3'b111 has no slave
    nxt(); req(1, 32'hF000_0000, 1'b1); settle();
    nxt(); settle();
    check_eq("um_gnt",   32'(gnt_o),   32'h2);
    check_eq("um_scyc",  32'(s_cyc_o), 32'h0);
    check_eq("um_noerr", 32'(m_err_o), 32'h0);
    check_eq("um_we",    32'(s_we_o),  32'h1);
    nxt(); settle();
    check_eq("um_err",   32'(m_err_o), 32'h2);
    nxt(); rel(1); settle();
    check_eq("um_err1",  32'(m_err_o), 32'h0);
    nxt();

    // GPIO never acks: watchdog fires 8 cycles after the strobe reaches it
    nxt(); req(0, 32'h8000_0000, 1'b0);
    nxt(); settle();
    check_eq("wd_sstb", 32'(s_stb_o), 32'h08);
    n = 0;
    while (m_err_o == '0 && n < 20) begin nxt(); settle(); n++; end
    check_eq("wd_lat1", 32'(n),       32'd8);
    check_eq("wd_err1", 32'(m_err_o), 32'h1);
    nxt(); m_stb[0] = 1'b0; settle();
    check_eq("wd_pulse", 32'(m_err_o), 32'h0);
    nxt(); m_stb[0] = 1'b1; settle();
    check_eq("wd_sstb2", 32'(s_stb_o), 32'h08);
    n = 0;
    while (m_err_o == '0 && n < 20) begin nxt(); settle(); n++; end
    check_eq("wd_lat2", 32'(n), 32'd8);
    nxt(); rel(0); settle();
    nxt();

    // Timer acks in the cycle the watchdog would fire
    ack_dly[4] = 8;
    nxt(); req(0, 32'hA000_0000, 1'b0);
    nxt(); settle();
    check_eq("aw_sstb", 32'(s_stb_o), 32'h10);
    n = 0;
    while ((m_ack_o | m_err_o) == '0 && n < 20) begin nxt(); settle(); n++; end
    check_eq("aw_lat",  32'(n),       32'd7);
    check_eq("aw_ack",  32'(m_ack_o), 32'h1);
    check_eq("aw_err",  32'(m_err_o), 32'h0);
    nxt(); rel(0); settle();
    check_eq("aw_err1", 32'(m_err_o), 32'h0);
    nxt();

    // Reset while SPI is mid-transfer; last release was master 0
    nxt(); req(0, 32'h6000_0000, 1'b0);
    nxt(); settle();
    check_eq("rs_scyc", 32'(s_cyc_o), 32'h04);
    nxt(); rst = 1'b0; settle();
    check_eq("rs_scyc0", 32'(s_cyc_o), 32'h0);
    check_eq("rs_sstb0", 32'(s_stb_o), 32'h0);
    check_eq("rs_gnt0",  32'(gnt_o),   32'h0);
    req(1, 32'h6000_0000, 1'b0);
    nxt(); rst = 1'b1; settle();
    check_eq("rs_gntr",  32'(gnt_o),   32'h0);
    nxt(); settle();
    check_eq("rs_win",   32'(gnt_o),   32'h1);
    rel(0); rel(1);
    nxt(); nxt();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
